// File: rtl/weight_sel_ctrl.sv
// Shares one up/down button pair across NUM_CHAN saturating 2-bit weights.
// Accepted edits are reported downstream over a valid/ready update port.
module weight_sel_ctrl #(
  parameter int NUM_CHAN   = 3,
  parameter int MAX_WEIGHT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  switch,
  input  logic                  up_button,
  input  logic                  down_button,
  input  logic                  next_button,
  output logic [2*NUM_CHAN-1:0] weights,
  output logic [1:0]            sel,
  output logic                  upd_valid,
  input  logic                  upd_ready,
  output logic [1:0]            upd_chan,
  output logic [1:0]            upd_weight
);

  localparam logic [1:0] MAX_W    = 2'(MAX_WEIGHT);
  localparam logic [1:0] LAST_SEL = 2'(NUM_CHAN - 1);

  typedef enum logic {
    UPD_IDLE,
    UPD_PENDING
  } upd_state_t;

  upd_state_t upd_state;
  logic [1:0] w_q [NUM_CHAN];

  logic up_prev;
  logic down_prev;
  logic next_prev;
  logic up_edge;
  logic down_edge;
  logic next_edge;

  logic [1:0] cur_w;
  logic [1:0] new_w;
  logic [1:0] next_sel;
  logic       edit_req;
  logic       edit_ok;

  // Prev registers track the raw level even in reset, so a button held
  // across reset release never looks like a fresh press.
  always_ff @(posedge clk) begin
    up_prev   <= up_button;
    down_prev <= down_button;
    next_prev <= next_button;
  end

  assign up_edge   = up_button & ~up_prev;
  assign down_edge = down_button & ~down_prev;
  assign next_edge = next_button & ~next_prev;

  always_comb begin
    cur_w = 2'd0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (2'(i) == sel) cur_w = w_q[i];
    end
  end

  // Simultaneous up and down cancel; edits are dropped while a record is pending.
  assign edit_req = switch && (up_edge ^ down_edge) && (upd_state == UPD_IDLE);
  assign edit_ok  = edit_req && (up_edge ? (cur_w < MAX_W) : (cur_w != 2'd0));
  assign new_w    = up_edge ? cur_w + 2'd1 : cur_w - 2'd1;
  assign next_sel = (sel == LAST_SEL) ? 2'd0 : sel + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_state  <= UPD_IDLE;
      sel        <= 2'd0;
      upd_chan   <= 2'd0;
      upd_weight <= 2'd0;
      for (int i = 0; i < NUM_CHAN; i++) w_q[i] <= 2'd0;
    end else begin
      if (upd_state == UPD_PENDING && upd_ready) upd_state <= UPD_IDLE;
      if (edit_ok) begin
        for (int i = 0; i < NUM_CHAN; i++) begin
          if (2'(i) == sel) w_q[i] <= new_w;
        end
        upd_state  <= UPD_PENDING;
        upd_chan   <= sel;
        upd_weight <= new_w;
      end
      if (switch && next_edge) sel <= next_sel;
    end
  end

  assign upd_valid = (upd_state == UPD_PENDING);

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_pack
    assign weights[2*g+1:2*g] = w_q[g];
  end

endmodule

// File: doc/weight_sel_ctrl.md
# weight_sel_ctrl

Front-panel controller that shares one pair of up/down buttons between several saturating weight registers. A third button cycles the selected channel, and a master switch gates all edits. Every accepted change is reported to the downstream mixer configuration logic over a valid/ready update port. The block sits between the raw panel inputs and the mixer, replacing per-channel button wiring.

## Interface
- NUM_CHAN, default 3: number of weight channels (2..4; sel is 2 bits).
- MAX_WEIGHT, default 2: saturation ceiling of each weight (1..3).
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- switch  in  1  edit enable; level-sensitive.
- up_button  in  1  increment request; raw level, single-cycle or held.
- down_button  in  1  decrement request; raw level.
- next_button  in  1  advance selected channel; raw level.
- weights  out  2*NUM_CHAN  packed weights; channel i at bits [2i+1:2i].
- sel  out  2  currently selected channel index.
- upd_valid  out  1  an update record is pending.
- upd_ready  in  1  consumer accepts the record when high with upd_valid.
- upd_chan  out  2  channel of the pending update.
- upd_weight  out  2  new weight value of the pending update.

## Operation
- Edge detect: the block keeps one prev register per button. An edge is button==1 && prev==0, sampled at posedge. Every button's prev register loads the current button level each cycle, including during reset. A button held through reset release therefore produces no edge.
- Reset: all weights 0, sel 0, upd_valid 0, upd_chan 0, upd_weight 0.
- switch==0: all three edges are ignored (no edit, no sel change). Weights and any pending handshake are retained.
- Up edge with switch==1, no down edge, and upd_valid==0:
  - If weight[sel] < MAX_WEIGHT, weight[sel] increments and an update is launched.
  - Otherwise nothing changes and no update is launched.
- Down edge under the same conditions: weight[sel] decrements if > 0 and an update is launched. At 0, nothing happens.
- Up and down edges in the same cycle: both are dropped.
- Up/down edge while upd_valid==1: dropped, not deferred.
- Next edge with switch==1: sel = (sel+1) mod NUM_CHAN, regardless of upd_valid.
- Next edge in the same cycle as an up/down edge: the edit applies to the old sel, and sel advances in the same posedge.
- Update launch: in the same posedge as the weight change, upd_valid←1, upd_chan←old sel, upd_weight←new value.
- Handshake:
  - upd_chan and upd_weight hold stable while upd_valid==1.
  - The record completes at the posedge where upd_valid && upd_ready; upd_valid is 0 the following cycle.
  - upd_ready while upd_valid==0 has no effect.
- Reset mid-handshake: the record is discarded (upd_valid←0).
- Weights are unsigned 2-bit. No wrap-around is ever possible, because the block saturates at 0 and at MAX_WEIGHT.

## Timing
- Button rising at input before posedge k: the effect is visible on weights, sel and upd_* right after posedge k. Latency is 1 clock.
- A held button yields exactly one edge. Releasing for at least 1 cycle and pressing again yields another edge.
- Minimum edit-to-edit spacing:
  - 2 cycles if upd_ready is tied high (valid for 1 cycle).
  - With a backpressured consumer, edits issued before acceptance are lost.
- All outputs are registered; there are no combinational input→output paths.

## Test plan
- Reset with up_button held high, then release reset with the button still held: weights stay 0, upd_valid stays 0. Release and press once: weight0=1, upd_valid=1, upd_chan=0, upd_weight=1.
- With upd_ready=1, switch=1, sel=0, apply three separate up presses then three down presses. Required: weight0 goes 1,2,2,1,0,0. Exactly 4 update records are produced; none is produced at either saturation point.
- With switch=0, press up, down and next: weights and sel are unchanged and there is no upd_valid. Set switch=1 and press next twice: sel=2. Press next a third time: sel wraps to 0 (NUM_CHAN=3).
- With upd_ready=0, press up on channel 1: upd_valid=1, chan=1, weight=1. Press up again: weight1 stays 1 and the record is unchanged. Raise upd_ready for 1 cycle: upd_valid=0 the next cycle.
- Press up and next in the same cycle at sel=0: weight0=1, upd_chan=0, sel=1. Press up and down in the same cycle: no change and no update.
- Assert reset while upd_valid=1 and weights are nonzero: next cycle all weights are 0, sel=0, upd_valid=0.
